// File: rtl/halut_pkg.sv
// Shared types and width helpers for the HALUT decoder controller.
//   ctrl_state_e : controller FSM encoding (IDLE, LOAD, DECODE, FLUSH)
//   cnt_width()  : width of a counter that must hold the values 0..depth
package halut_pkg;

    typedef enum logic [1:0] {
        CS_IDLE   = 2'd0,
        CS_LOAD   = 2'd1,
        CS_DECODE = 2'd2,
        CS_FLUSH  = 2'd3
    } ctrl_state_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/halut_result_fifo.sv
// First-word-fall-through result buffer for decoder row results.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write side, ignored while full
//   pop_i         : read side, ignored while empty
//   data_o        : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy status
module halut_result_fifo
    import halut_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 4,
    parameter int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    parameter int unsigned CntWidth = cnt_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] count_o
);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wptr_q, rptr_q;
    logic [CntWidth-1:0] count_q;
    logic                do_push, do_pop;

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until count_q says it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/halut_decoder_ctrl.sv
// Sequencer for one halut_decoder lane: loads the C x K LUT, streams
// prototype indices to the decoder, closes batches with a flush beat and
// buffers row results, reserving a buffer slot before each row starts.
//   lut_valid_i/lut_ready_o/lut_data_i : LUT word stream (c-major, then k)
//   load_done_o                       : pulse once the last LUT word is issued
//   idx_valid_i/idx_ready_o/idx_k_i/idx_last_i : encoded index stream
//   dec_waddr_o/dec_wdata_o/dec_we_o   : decoder LUT write port (registered)
//   dec_c_addr_o/dec_k_addr_o/dec_en_o : decoder read/accumulate (registered)
//   dec_valid_i/dec_result_i           : decoder row result
//   res_valid_o/res_ready_i/res_data_o : FP32 result stream
//   err_o : sticky protocol error      busy_o : not idle or credits held
//
// state  | meaning
// IDLE   | waiting; LUT word has priority over an index
// LOAD   | accepting LUT words into the decoder
// DECODE | inside a row or between rows of a batch
// FLUSH  | one c=0,k=0 beat to push the last row through the decoder
module halut_decoder_ctrl
    import halut_pkg::*;
#(
    parameter int unsigned C               = 32,
    parameter int unsigned K               = 16,
    parameter int unsigned DataTypeWidth   = 16,
    parameter int unsigned ResultFifoDepth = 4,
    parameter int unsigned TotalAddrWidth  = $clog2(C * K),
    parameter int unsigned CAddrWidth      = $clog2(C),
    parameter int unsigned TreeDepth       = $clog2(K)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      lut_valid_i,
    output logic                      lut_ready_o,
    input  logic [DataTypeWidth-1:0]  lut_data_i,
    output logic                      load_done_o,
    input  logic                      idx_valid_i,
    output logic                      idx_ready_o,
    input  logic [TreeDepth-1:0]      idx_k_i,
    input  logic                      idx_last_i,
    output logic [TotalAddrWidth-1:0] dec_waddr_o,
    output logic [DataTypeWidth-1:0]  dec_wdata_o,
    output logic                      dec_we_o,
    output logic [CAddrWidth-1:0]     dec_c_addr_o,
    output logic [TreeDepth-1:0]      dec_k_addr_o,
    output logic                      dec_en_o,
    input  logic                      dec_valid_i,
    input  logic [31:0]               dec_result_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [31:0]               res_data_o,
    output logic                      err_o,
    output logic                      busy_o
);

    localparam logic [1:0] ST_IDLE   = CS_IDLE;
    localparam logic [1:0] ST_LOAD   = CS_LOAD;
    localparam logic [1:0] ST_DECODE = CS_DECODE;
    localparam logic [1:0] ST_FLUSH  = CS_FLUSH;

    localparam int unsigned CreditWidth = cnt_width(ResultFifoDepth);
    localparam logic [CAddrWidth-1:0]     CLast     = CAddrWidth'(C - 1);
    localparam logic [TotalAddrWidth-1:0] WLast     = TotalAddrWidth'(C * K - 1);
    localparam logic [CreditWidth-1:0]    CreditMax = CreditWidth'(ResultFifoDepth);

    logic [1:0]                state_q;
    logic [CAddrWidth-1:0]     c_cnt_q;
    logic [TotalAddrWidth-1:0] waddr_cnt_q;
    logic [CreditWidth-1:0]    reserved_q;
    logic                      active_q;

    logic                   lut_prio, lut_hs, idx_hs, row_start, res_pop, credit_ok;
    logic                   fifo_full, fifo_empty, fifo_push;
    logic [CreditWidth-1:0] fifo_count;

    assign lut_prio    = (state_q == ST_IDLE) && lut_valid_i;
    assign lut_ready_o = (state_q == ST_LOAD);
    assign lut_hs      = lut_valid_i && lut_ready_o;
    // A row may only start with a free result slot; mid-row indices never stall on credits.
    assign credit_ok   = (c_cnt_q != '0) || (reserved_q < CreditMax);
    // active_q holds ready low while reset is asserted.
    assign idx_ready_o = active_q && ((state_q == ST_IDLE) || (state_q == ST_DECODE))
                         && !lut_prio && credit_ok;
    assign idx_hs      = idx_valid_i && idx_ready_o;
    assign row_start   = idx_hs && (c_cnt_q == '0);
    assign res_valid_o = !fifo_empty;
    assign res_pop     = res_valid_o && res_ready_i;
    assign fifo_push   = dec_valid_i && !fifo_full;
    assign busy_o      = (state_q != ST_IDLE) || (reserved_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            c_cnt_q      <= '0;
            waddr_cnt_q  <= '0;
            reserved_q   <= '0;
            active_q     <= 1'b0;
            err_o        <= 1'b0;
            load_done_o  <= 1'b0;
            dec_waddr_o  <= '0;
            dec_wdata_o  <= '0;
            dec_we_o     <= 1'b0;
            dec_c_addr_o <= '0;
            dec_k_addr_o <= '0;
            dec_en_o     <= 1'b0;
        end else begin
            active_q    <= 1'b1;
            load_done_o <= 1'b0;
            dec_we_o    <= lut_hs;
            dec_en_o    <= 1'b0;
            if (lut_hs) begin
                dec_waddr_o <= waddr_cnt_q;
                dec_wdata_o <= lut_data_i;
            end

            case (state_q)
                ST_IDLE: begin
                    if (lut_valid_i) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (lut_hs) begin
                        if (waddr_cnt_q == WLast) begin
                            waddr_cnt_q <= '0;
                            state_q     <= ST_IDLE;
                            load_done_o <= 1'b1;
                        end else begin
                            waddr_cnt_q <= waddr_cnt_q + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    dec_en_o     <= 1'b1;
                    dec_c_addr_o <= '0;
                    dec_k_addr_o <= '0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                end
            endcase

            if (idx_hs) begin
                dec_en_o     <= 1'b1;
                dec_c_addr_o <= c_cnt_q;
                dec_k_addr_o <= idx_k_i;
                if (idx_last_i) begin
                    state_q <= ST_FLUSH;
                    c_cnt_q <= '0;
                    if (c_cnt_q != CLast) err_o <= 1'b1;
                end else begin
                    state_q <= ST_DECODE;
                    c_cnt_q <= (c_cnt_q == CLast) ? '0 : c_cnt_q + 1'b1;
                end
            end

            // A result is only legal while some reserved slot is still unfilled.
            if (dec_valid_i && (fifo_full || (reserved_q <= fifo_count))) err_o <= 1'b1;

            if (row_start && !res_pop)      reserved_q <= reserved_q + 1'b1;
            else if (!row_start && res_pop) reserved_q <= reserved_q - 1'b1;
        end
    end

    halut_result_fifo #(
        .Width (32),
        .Depth (ResultFifoDepth)
    ) u_result_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (dec_result_i),
        .pop_i   (res_ready_i),
        .data_o  (res_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_halut_decoder_ctrl.sv
module tb_halut_decoder_ctrl;

    localparam int DW  = 16;
    localparam int TAW = 9;
    localparam int CAW = 5;
    localparam int TD  = 4;
    localparam logic [31:0] RB = 32'hC0DE_0000;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           lut_valid_i = 1'b0;
    logic           lut_ready_o;
    logic [DW-1:0]  lut_data_i = '0;
    logic           load_done_o;
    logic           idx_valid_i = 1'b0;
    logic           idx_ready_o;
    logic [TD-1:0]  idx_k_i = '0;
    logic           idx_last_i = 1'b0;
    logic [TAW-1:0] dec_waddr_o;
    logic [DW-1:0]  dec_wdata_o;
    logic           dec_we_o;
    logic [CAW-1:0] dec_c_addr_o;
    logic [TD-1:0]  dec_k_addr_o;
    logic           dec_en_o;
    logic           dec_valid_i = 1'b0;
    logic [31:0]    dec_result_i = '0;
    logic           res_valid_o;
    logic           res_ready_i = 1'b0;
    logic [31:0]    res_data_o;
    logic           err_o;
    logic           busy_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] popped[$];

    halut_decoder_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lut_valid_i  (lut_valid_i),
        .lut_ready_o  (lut_ready_o),
        .lut_data_i   (lut_data_i),
        .load_done_o  (load_done_o),
        .idx_valid_i  (idx_valid_i),
        .idx_ready_o  (idx_ready_o),
        .idx_k_i      (idx_k_i),
        .idx_last_i   (idx_last_i),
        .dec_waddr_o  (dec_waddr_o),
        .dec_wdata_o  (dec_wdata_o),
        .dec_we_o     (dec_we_o),
        .dec_c_addr_o (dec_c_addr_o),
        .dec_k_addr_o (dec_k_addr_o),
        .dec_en_o     (dec_en_o),
        .dec_valid_i  (dec_valid_i),
        .dec_result_i (dec_result_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (res_valid_o && res_ready_i) popped.push_back(res_data_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_idx(input logic [TD-1:0] k, input logic last);
        int waited = 0;
        idx_valid_i = 1'b1;
        idx_k_i     = k;
        idx_last_i  = last;
        @(negedge clk_i);
        while (!idx_ready_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        checks++;
        if (idx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL idx_timeout ready=%0b required=1", idx_ready_o);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({dec_we_o, dec_en_o, lut_ready_o, idx_ready_o, res_valid_o, load_done_o, err_o, busy_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got=%b required=00000000",
                     {dec_we_o, dec_en_o, lut_ready_o, idx_ready_o, res_valid_o, load_done_o, err_o, busy_o});
        end
        checks++;
        if ({dec_waddr_o, dec_wdata_o, dec_c_addr_o, dec_k_addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_dec_bus got=%h required=0", {dec_waddr_o, dec_wdata_o, dec_c_addr_o, dec_k_addr_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++;
        if (idx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_idx_ready got=%0b required=1", idx_ready_o);
        end
    endtask

    task automatic test_lut_load();
        int waited;
        lut_valid_i = 1'b1;
        for (int i = 0; i < 512; i++) begin
            lut_data_i = DW'(i);
            waited = 0;
            @(negedge clk_i);
            if (i == 0) begin
                checks++;
                if (idx_ready_o !== 1'b0 || lut_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL lut_idle_prio idx_ready=%0b lut_ready=%0b required=0,0", idx_ready_o, lut_ready_o);
                end
            end
            while (!lut_ready_o && waited < 10) begin
                waited++;
                @(negedge clk_i);
            end
            if (i > 0) begin
                checks++;
                if (waited != 0) begin
                    errors++;
                    $display("FAIL lut_throughput word=%0d stall=%0d required=0", i, waited);
                end
            end
            tick();
            checks++;
            if ({dec_we_o, dec_waddr_o, dec_wdata_o} !== {1'b1, TAW'(i), DW'(i)}) begin
                errors++;
                $display("FAIL lut_write word=%0d we=%0b waddr=%0d wdata=%0h required we=1 waddr=wdata=%0d",
                         i, dec_we_o, dec_waddr_o, dec_wdata_o, i);
            end
            checks++;
            if (load_done_o !== (i == 511)) begin
                errors++;
                $display("FAIL load_done word=%0d got=%0b required=%0b", i, load_done_o, (i == 511));
            end
        end
        lut_valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL lut_return_idle busy=%0b required=0", busy_o);
        end
        tick();
        checks++;
        if ({load_done_o, dec_we_o} !== 2'b00) begin
            errors++;
            $display("FAIL lut_after done=%0b we=%0b required=0,0", load_done_o, dec_we_o);
        end
    endtask

    task automatic test_one_row();
        for (int c = 0; c < 32; c++) begin
            send_idx(TD'(c % 16), (c == 31));
            checks++;
            if ({dec_en_o, dec_c_addr_o, dec_k_addr_o} !== {1'b1, CAW'(c), TD'(c % 16)}) begin
                errors++;
                $display("FAIL row_issue c=%0d en=%0b c_addr=%0d k_addr=%0d required 1,%0d,%0d",
                         c, dec_en_o, dec_c_addr_o, dec_k_addr_o, c, c % 16);
            end
        end
        idx_valid_i = 1'b0;
        idx_last_i  = 1'b0;
        tick();
        checks++;
        if ({dec_en_o, dec_c_addr_o, dec_k_addr_o} !== {1'b1, CAW'(0), TD'(0)}) begin
            errors++;
            $display("FAIL row_flush en=%0b c=%0d k=%0d required 1,0,0", dec_en_o, dec_c_addr_o, dec_k_addr_o);
        end
        tick();
        checks++;
        if ({dec_en_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL row_post_flush en=%0b busy=%0b required 0,1", dec_en_o, busy_o);
        end
        dec_valid_i  = 1'b1;
        dec_result_i = 32'hA5A5_0001;
        tick();
        dec_valid_i = 1'b0;
        checks++;
        if ({res_valid_o, res_data_o} !== {1'b1, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL row_result valid=%0b data=%h required 1,a5a50001", res_valid_o, res_data_o);
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        checks++;
        if ({res_valid_o, busy_o, err_o} !== 3'b000) begin
            errors++;
            $display("FAIL row_drained valid=%0b busy=%0b err=%0b required 0,0,0", res_valid_o, busy_o, err_o);
        end
    endtask

    task automatic test_gaps();
        int gap;
        for (int c = 0; c < 32; c++) begin
            gap = (c % 3 == 1) ? 2 : ((c % 5 == 2) ? 1 : 0);
            for (int g = 0; g < gap; g++) begin
                idx_valid_i = 1'b0;
                tick();
                checks++;
                if (dec_en_o !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_en c=%0d en=%0b required 0", c, dec_en_o);
                end
            end
            send_idx(TD'((c * 3) % 16), (c == 31));
            checks++;
            if ({dec_en_o, dec_c_addr_o, dec_k_addr_o} !== {1'b1, CAW'(c), TD'((c * 3) % 16)}) begin
                errors++;
                $display("FAIL gap_issue c=%0d en=%0b c_addr=%0d k_addr=%0d required 1,%0d,%0d",
                         c, dec_en_o, dec_c_addr_o, dec_k_addr_o, c, (c * 3) % 16);
            end
        end
        idx_valid_i = 1'b0;
        idx_last_i  = 1'b0;
        tick();
        checks++;
        if ({dec_en_o, dec_c_addr_o, dec_k_addr_o} !== {1'b1, CAW'(0), TD'(0)}) begin
            errors++;
            $display("FAIL gap_flush en=%0b c=%0d k=%0d required 1,0,0", dec_en_o, dec_c_addr_o, dec_k_addr_o);
        end
        dec_valid_i  = 1'b1;
        dec_result_i = 32'h0000_0BAD;
        tick();
        dec_valid_i = 1'b0;
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        checks++;
        if ({busy_o, err_o} !== 2'b00) begin
            errors++;
            $display("FAIL gap_drained busy=%0b err=%0b required 0,0", busy_o, err_o);
        end
    endtask

    task automatic row_b2b(input int r, input logic last_row);
        for (int c = 0; c < 32; c++) begin
            if (c == 1 && r >= 1) begin
                dec_valid_i  = 1'b1;
                dec_result_i = RB + 32'(r - 1);
            end
            send_idx(TD'((c + r) % 16), last_row && (c == 31));
            dec_valid_i = 1'b0;
            checks++;
            if ({dec_en_o, dec_c_addr_o} !== {1'b1, CAW'(c)}) begin
                errors++;
                $display("FAIL b2b_issue row=%0d c=%0d en=%0b c_addr=%0d", r, c, dec_en_o, dec_c_addr_o);
            end
            if (r == 4 && c == 0) res_ready_i = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        res_ready_i = 1'b0;
        popped.delete();
        for (int r = 0; r < 4; r++) row_b2b(r, 1'b0);
        idx_valid_i = 1'b1;
        idx_k_i     = '0;
        idx_last_i  = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk_i);
            checks++;
            if (idx_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_credit_block cycle=%0d ready=%0b required 0", n, idx_ready_o);
            end
            tick();
        end
        checks++;
        if ({res_valid_o, res_data_o} !== {1'b1, RB}) begin
            errors++;
            $display("FAIL b2b_head valid=%0b data=%h required 1,%h", res_valid_o, res_data_o, RB);
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        idx_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (idx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_credit_return ready=%0b required 1", idx_ready_o);
        end
        tick();
        row_b2b(4, 1'b0);
        row_b2b(5, 1'b1);
        idx_valid_i = 1'b0;
        idx_last_i  = 1'b0;
        tick();
        dec_valid_i  = 1'b1;
        dec_result_i = RB + 32'd5;
        tick();
        dec_valid_i = 1'b0;
        repeat (8) tick();
        res_ready_i = 1'b0;
        checks++;
        if (popped.size() != 6) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=6", popped.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < popped.size()) begin
                checks++;
                if (popped[i] !== RB + 32'(i)) begin
                    errors++;
                    $display("FAIL b2b_order idx=%0d got=%h required=%h", i, popped[i], RB + 32'(i));
                end
            end
        end
        checks++;
        if ({busy_o, err_o} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end busy=%0b err=%0b required 0,0", busy_o, err_o);
        end
    endtask

    task automatic test_err_lut_hold_reset();
        for (int c = 0; c < 11; c++) begin
            send_idx(TD'(c % 16), (c == 10));
            if (c == 9) begin
                checks++;
                if (err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL err_early got=%0b required 0", err_o);
                end
            end
        end
        idx_valid_i = 1'b0;
        idx_last_i  = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_short_row got=%0b required 1", err_o);
        end
        tick();
        checks++;
        if ({dec_en_o, dec_c_addr_o, dec_k_addr_o} !== {1'b1, CAW'(0), TD'(0)}) begin
            errors++;
            $display("FAIL err_flush en=%0b c=%0d k=%0d required 1,0,0", dec_en_o, dec_c_addr_o, dec_k_addr_o);
        end
        dec_valid_i  = 1'b1;
        dec_result_i = 32'hEEEE_0000;
        tick();
        dec_valid_i = 1'b0;
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        send_idx(TD'(3), 1'b0);
        checks++;
        if ({dec_en_o, dec_c_addr_o, dec_k_addr_o, err_o} !== {1'b1, CAW'(0), TD'(3), 1'b1}) begin
            errors++;
            $display("FAIL err_next_row en=%0b c=%0d k=%0d err=%0b required 1,0,3,1",
                     dec_en_o, dec_c_addr_o, dec_k_addr_o, err_o);
        end
        lut_valid_i = 1'b1;
        lut_data_i  = 16'hBEEF;
        for (int c = 1; c < 32; c++) begin
            send_idx(TD'(c % 16), (c == 31));
            checks++;
            if ({lut_ready_o, dec_we_o, dec_c_addr_o} !== {1'b0, 1'b0, CAW'(c)}) begin
                errors++;
                $display("FAIL lut_held c=%0d lut_ready=%0b we=%0b c_addr=%0d required 0,0,%0d",
                         c, lut_ready_o, dec_we_o, dec_c_addr_o, c);
            end
        end
        idx_valid_i = 1'b0;
        idx_last_i  = 1'b0;
        tick();
        checks++;
        if ({lut_ready_o, idx_ready_o, dec_en_o} !== 3'b001) begin
            errors++;
            $display("FAIL lut_hold_idle lut_ready=%0b idx_ready=%0b en=%0b required 0,0,1",
                     lut_ready_o, idx_ready_o, dec_en_o);
        end
        tick();
        checks++;
        if ({lut_ready_o, dec_we_o} !== 2'b10) begin
            errors++;
            $display("FAIL lut_hold_load lut_ready=%0b we=%0b required 1,0", lut_ready_o, dec_we_o);
        end
        tick();
        checks++;
        if ({dec_we_o, dec_waddr_o, dec_wdata_o} !== {1'b1, TAW'(0), 16'hBEEF}) begin
            errors++;
            $display("FAIL lut_hold_word we=%0b waddr=%0d wdata=%h required 1,0,beef", dec_we_o, dec_waddr_o, dec_wdata_o);
        end
        for (int i = 1; i < 5; i++) begin
            lut_data_i = DW'(i);
            tick();
            checks++;
            if ({dec_we_o, dec_waddr_o} !== {1'b1, TAW'(i)}) begin
                errors++;
                $display("FAIL lut_partial word=%0d we=%0b waddr=%0d", i, dec_we_o, dec_waddr_o);
            end
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({lut_ready_o, dec_we_o, busy_o, err_o, idx_ready_o} !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset lut_ready=%0b we=%0b busy=%0b err=%0b idx_ready=%0b required all 0",
                     lut_ready_o, dec_we_o, busy_o, err_o, idx_ready_o);
        end
        lut_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++;
        if ({idx_ready_o, busy_o, err_o} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset idx_ready=%0b busy=%0b err=%0b required 1,0,0", idx_ready_o, busy_o, err_o);
        end
        lut_valid_i = 1'b1;
        lut_data_i  = 16'h1234;
        tick();
        tick();
        checks++;
        if ({dec_we_o, dec_waddr_o, dec_wdata_o} !== {1'b1, TAW'(0), 16'h1234}) begin
            errors++;
            $display("FAIL reload_addr we=%0b waddr=%0d wdata=%h required 1,0,1234", dec_we_o, dec_waddr_o, dec_wdata_o);
        end
        lut_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lut_load();
        test_one_row();
        test_gaps();
        test_back_to_back();
        test_err_lut_hold_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
